// File: rtl/uart_cmd_rx_pkg.sv
// rtl/uart_cmd_rx_pkg.sv - shared encodings and register map for the UART command receiver
package uart_cmd_rx_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam logic [7:0] ADDR_SETPOINT = 8'h01;
    localparam logic [7:0] ADDR_KP       = 8'h02;
    localparam logic [7:0] ADDR_KI       = 8'h03;
    localparam logic [7:0] ADDR_KD       = 8'h04;
    localparam logic [7:0] ADDR_MODE     = 8'h05;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    typedef enum logic [2:0] {
        F_HUNT,
        F_ADDR,
        F_DHI,
        F_DLO,
        F_CSUM
    } frame_state_t;

    function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                              input logic [7:0] data_hi,
                                              input logic [7:0] data_lo);
        return addr ^ data_hi ^ data_lo;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 2-FF synchroniser and 8N1 byte deserialiser
module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err,
    output logic       active
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta;
    logic          rx_s;
    byte_state_t   state_q;
    byte_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tick;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // tick marks the cycle on which the line is sampled in the current state
    always_comb begin
        state_d    = state_q;
        tick       = 1'b0;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state_q)
            B_IDLE: begin
                if (!rx_s) state_d = B_START;
            end
            B_START: begin
                if (cnt_q == HALF_LAST) begin
                    tick    = 1'b1;
                    state_d = rx_s ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    tick = 1'b1;
                    if (bit_q == 3'd7) state_d = B_STOP;
                end
            end
            B_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    tick       = 1'b1;
                    state_d    = B_IDLE;
                    byte_valid = rx_s;
                    stop_err   = !rx_s;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == B_IDLE || tick) cnt_q <= '0;
            else                           cnt_q <= cnt_q + 1'b1;
            if (state_q == B_IDLE) bit_q <= '0;
            if (state_q == B_DATA && tick) begin
                shift_q <= {rx_s, shift_q[7:1]};
                bit_q   <= bit_q + 1'b1;
            end
        end
    end

    assign byte_data = shift_q;
    assign active    = (state_q != B_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 5-byte command frame assembler producing register-write strobes
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  HEADER       = HEADER_DEFAULT,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        rx,
    output logic        o_wr_valid,
    output logic [7:0]  o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         stop_err;
    logic         byte_active;
    frame_state_t frame_q;
    frame_state_t frame_d;
    logic [7:0]   addr_q;
    logic [7:0]   dhi_q;
    logic [7:0]   dlo_q;
    logic [TW-1:0] to_cnt_q;
    logic         to_run;
    logic         to_hit;
    logic         accept;
    logic         reject;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err),
        .active     (byte_active)
    );

    assign to_run = (frame_q != F_HUNT) && !byte_active;
    assign to_hit = to_run && (to_cnt_q == TO_LAST);

    always_comb begin
        frame_d = frame_q;
        accept  = 1'b0;
        reject  = 1'b0;
        if (stop_err || to_hit) begin
            frame_d = F_HUNT;
            reject  = 1'b1;
        end else if (byte_valid) begin
            case (frame_q)
                F_HUNT: if (byte_data == HEADER) frame_d = F_ADDR;
                F_ADDR: frame_d = F_DHI;
                F_DHI:  frame_d = F_DLO;
                F_DLO:  frame_d = F_CSUM;
                F_CSUM: begin
                    frame_d = F_HUNT;
                    accept  = (byte_data == frame_csum(addr_q, dhi_q, dlo_q));
                    reject  = !accept;
                end
                default: frame_d = F_HUNT;
            endcase
        end
    end

    // to_cnt counts clocks since the last stop sample, so the registered error
    // strobe lands exactly TO_LIMIT clocks after it
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            frame_q     <= F_HUNT;
            addr_q      <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            to_cnt_q    <= '0;
            o_wr_valid  <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            frame_q     <= frame_d;
            o_wr_valid  <= accept;
            o_frame_err <= reject;
            if (byte_valid) begin
                case (frame_q)
                    F_ADDR:  addr_q <= byte_data;
                    F_DHI:   dhi_q  <= byte_data;
                    F_DLO:   dlo_q  <= byte_data;
                    default: ;
                endcase
            end
            if (byte_valid)             to_cnt_q <= TW'(1);
            else if (to_run)            to_cnt_q <= to_cnt_q + 1'b1;
            else if (frame_q == F_HUNT) to_cnt_q <= '0;
            if (accept) begin
                o_wr_addr <= addr_q;
                o_wr_data <= {dhi_q, dlo_q};
            end
        end
    end

    assign o_busy = byte_active || (frame_q != F_HUNT);

endmodule
